// File: rtl/pim_dma_ctrl.sv
// pim_dma_ctrl: DMA sequencer between the shared data memory and the PIM
// macro buffers. It also launches PIM compute. Commands come from the core's
// DMA instruction. The core stalls while dma_busy_o is high.
module pim_dma_ctrl #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_PIM = 4,
  parameter int unsigned PIM_AW  = 10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               dma_en_i,
  input  logic [2:0]         dma_funct3_i,
  input  logic [NUM_PIM-1:0] dma_sel_pim_i,
  input  logic [12:0]        dma_size_i,
  input  logic [XLEN-1:0]    dma_mem_addr_i,
  output logic               dma_busy_o,
  output logic               mem_req_o,
  input  logic               mem_gnt_i,
  output logic [XLEN-1:0]    mem_addr_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic [3:0]         mem_size_o,
  output logic [XLEN-1:0]    mem_wr_data_o,
  input  logic [XLEN-1:0]    mem_rd_data_i,
  output logic [NUM_PIM-1:0] pim_sel_o,
  output logic [PIM_AW-1:0]  pim_addr_o,
  output logic               pim_write_o,
  output logic               pim_read_o,
  output logic [XLEN-1:0]    pim_wr_data_o,
  input  logic [XLEN-1:0]    pim_rd_data_i,
  output logic               pim_start_o,
  input  logic               pim_done_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOAD_DRAIN,
    S_ST_RD,
    S_ST_WR,
    S_START,
    S_WAIT,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_PIM-1:0] mask_q, mask_d;
  logic [11:0]        words_q, words_d;
  logic [11:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]    maddr_q, maddr_d;
  logic [PIM_AW-1:0]  paddr_q, paddr_d;
  logic               wr_pend_q, wr_pend_d;
  logic               st_first_q, st_first_d;
  logic [XLEN-1:0]    hold_q, hold_d;

  logic [13:0]        size_rnd;
  logic [11:0]        cmd_words;
  logic [11:0]        cnt_inc;
  logic [NUM_PIM-1:0] store_tgt;
  logic               unused_bits;

  // Command word count: ceil(size/4); the top 12 bits of (size+3) cover sizes up to 8191.
  assign size_rnd    = {1'b0, dma_size_i} + 14'd3;
  assign cmd_words   = size_rnd[13:2];
  assign cnt_inc     = cnt_q + 12'd1;
  // Stores read only from the lowest selected macro.
  assign store_tgt   = mask_q & (~mask_q + NUM_PIM'(1));
  assign unused_bits = ^{size_rnd[1:0], dma_mem_addr_i[1:0]};
  assign mem_size_o  = 4'b1111;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      mask_q     <= '0;
      words_q    <= '0;
      cnt_q      <= '0;
      maddr_q    <= '0;
      paddr_q    <= '0;
      wr_pend_q  <= 1'b0;
      st_first_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      words_q    <= words_d;
      cnt_q      <= cnt_d;
      maddr_q    <= maddr_d;
      paddr_q    <= paddr_d;
      wr_pend_q  <= wr_pend_d;
      st_first_q <= st_first_d;
      hold_q     <= hold_d;
    end
  end

  // Next-state and counter/address update logic.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    words_d    = words_q;
    cnt_d      = cnt_q;
    maddr_d    = maddr_q;
    paddr_d    = paddr_q;
    wr_pend_d  = 1'b0;
    st_first_d = 1'b0;
    hold_d     = hold_q;

    // A LOAD PIM write lands one cycle after its read was issued. The write address follows the writes, not the issues.
    if (wr_pend_q) paddr_d = paddr_q + PIM_AW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (dma_en_i) begin
          mask_d  = dma_sel_pim_i;
          words_d = cmd_words;
          cnt_d   = '0;
          maddr_d = {dma_mem_addr_i[XLEN-1:2], 2'b00};
          paddr_d = '0;
          hold_d  = '0;
          if (cmd_words == 12'd0 || dma_sel_pim_i == '0) begin
            state_d = S_DONE;
          end else begin
            unique case (dma_funct3_i)
              3'b000:  state_d = S_LOAD;
              3'b001:  state_d = S_ST_RD;
              3'b010:  state_d = S_START;
              default: state_d = S_DONE;
            endcase
          end
        end
      end
      S_LOAD: begin
        if (mem_gnt_i) begin
          wr_pend_d = 1'b1;
          maddr_d   = maddr_q + XLEN'(4);
          cnt_d     = cnt_inc;
          if (cnt_inc == words_q) state_d = S_LOAD_DRAIN;
        end
      end
      S_LOAD_DRAIN: state_d = S_DONE;
      S_ST_RD: begin
        state_d    = S_ST_WR;
        st_first_d = 1'b1;
      end
      S_ST_WR: begin
        // PIM read data is only valid in the first ST_WR cycle. It is held here for any later grant wait.
        if (st_first_q) hold_d = pim_rd_data_i;
        if (mem_gnt_i) begin
          maddr_d = maddr_q + XLEN'(4);
          paddr_d = paddr_q + PIM_AW'(1);
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == words_q) ? S_DONE : S_ST_RD;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT:  if (pim_done_i) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from registered state; read data is forwarded on the cycle it becomes valid.
  always_comb begin
    dma_busy_o    = (state_q != S_IDLE);
    mem_req_o     = 1'b0;
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    mem_addr_o    = '0;
    mem_wr_data_o = '0;
    pim_sel_o     = '0;
    pim_addr_o    = '0;
    pim_write_o   = 1'b0;
    pim_read_o    = 1'b0;
    pim_wr_data_o = '0;
    pim_start_o   = 1'b0;

    unique case (state_q)
      S_LOAD: begin
        mem_req_o  = 1'b1;
        mem_read_o = 1'b1;
        mem_addr_o = maddr_q;
      end
      S_ST_RD: begin
        pim_read_o = 1'b1;
        pim_sel_o  = store_tgt;
        pim_addr_o = paddr_q;
      end
      S_ST_WR: begin
        mem_req_o     = 1'b1;
        mem_write_o   = 1'b1;
        mem_addr_o    = maddr_q;
        mem_wr_data_o = st_first_q ? pim_rd_data_i : hold_q;
      end
      S_START: begin
        pim_start_o = 1'b1;
        pim_sel_o   = mask_q;
      end
      default: ;
    endcase

    if (wr_pend_q) begin
      pim_write_o   = 1'b1;
      pim_sel_o     = mask_q;
      pim_addr_o    = paddr_q;
      pim_wr_data_o = mem_rd_data_i;
    end
  end

endmodule
